// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin transmit scheduler that shares one uart_tx
// serializer among NREQ byte producers.
//
// On an IDLE edge it picks the next valid requester after the last one served,
// captures its byte and parity bit, and then pulses tx_enable and that
// requester's req_ready for one cycle. It follows tx_sending through the
// frame, enforces an optional idle gap, and flags a serializer that never
// starts (start_err).
//
// Ports:
//   baud_clk    16x oversample clock. All state changes on its rising edge.
//   reset       asynchronous, active-low
//   req_valid   per-requester byte available (held until req_ready)
//   req_data    requester i byte at [8*i+7:8*i]
//   req_ready   one-hot, one-cycle accept pulse
//   parity_odd  0 = even parity, 1 = odd parity (sampled at capture)
//   err_clr     clears start_err (a coincident timeout wins)
//   tx_enable   one-cycle enable pulse to uart_tx
//   tx_din      captured byte, held until the next capture
//   tx_parity   parity bit of tx_din, held like tx_din
//   tx_sending  sending flag from uart_tx
//   busy        high whenever the scheduler is not idle
//   grant_id    index of the last captured requester
//   start_err   sticky: serializer failed to start a frame
module uart_tx_sched #(
    parameter int NREQ          = 4,
    parameter int ID_W          = 2,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 4
) (
    input  logic              baud_clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              parity_odd,
    input  logic              err_clr,
    output logic              tx_enable,
    output logic [7:0]        tx_din,
    output logic              tx_parity,
    input  logic              tx_sending,
    output logic              busy,
    output logic [ID_W-1:0]   grant_id,
    output logic              start_err
);

    // One counter serves both the start timeout and the idle gap.
    localparam int CNT_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_START,
        ST_BUSY,
        ST_GAP
    } state_t;

    state_t           state, state_next;
    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  cand;
    logic             any_valid;
    logic [7:0]       win_byte;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             capture;
    logic             timeout;

    // Round-robin search starting after the last winner. Scanning from the
    // farthest candidate down to the nearest lets the nearest valid one
    // overwrite the others, so no early exit is needed.
    always_comb begin : arbiter
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        any_valid = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = ID_W'((int'(last) + k) % NREQ);
            if (req_valid[cand]) begin
                any_valid = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign win_byte = req_data[{win_id, 3'b000} +: 8];

    always_comb begin : next_state
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    capture    = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_next   = '0;
                state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (tx_sending) begin
                    state_next = ST_BUSY;
                end else if (cnt == TIMEOUT_LAST) begin
                    // This cycle's increment would reach START_TIMEOUT. The
                    // byte was already acked, so it is simply dropped.
                    timeout    = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_BUSY: begin
                if (!tx_sending) begin
                    cnt_next   = '0;
                    state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            last      <= ID_W'(NREQ - 1);
            grant_id  <= '0;
            tx_din    <= '0;
            tx_parity <= 1'b0;
            start_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here updates
            // from the values that were present before the clock edge.
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                tx_din    <= win_byte;
                tx_parity <= (^win_byte) ^ parity_odd;
                grant_id  <= win_id;
                last      <= win_id;
            end
            if (timeout) begin
                start_err <= 1'b1;
            end else if (err_clr) begin
                start_err <= 1'b0;
            end
        end
    end

    // These outputs decode the state register directly. Asserting reset
    // therefore drops them at once, and tx_enable cannot stay high.
    assign tx_enable = (state == ST_LAUNCH);
    assign req_ready = tx_enable ? (NREQ'(1) << grant_id) : '0;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched. A cycle-level uart_tx model answers
// tx_enable with a framed sending pulse and records the serial line.
// Expected grants come from a round-robin reference over the pending set.
// A second instance built with GAP_CYCLES=0 checks the back-to-back timing.
module tb_uart_tx_sched;

    localparam int NREQ      = 4;
    localparam int ID_W      = 2;
    localparam int GAP       = 16;
    localparam int TMO       = 4;
    localparam int BIT_CYC   = 16;
    localparam int FRAME_CYC = BIT_CYC * 11;
    localparam int SPACING   = FRAME_CYC + GAP + 3;

    logic              baud_clk = 1'b0;
    logic              reset    = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ready;
    logic              parity_odd = 1'b0;
    logic              err_clr    = 1'b0;
    logic              tx_enable;
    logic [7:0]        tx_din;
    logic              tx_parity;
    logic              tx_sending = 1'b0;
    logic              busy;
    logic [ID_W-1:0]   grant_id;
    logic              start_err;

    logic [NREQ-1:0]   req_valid0 = '0;
    logic [8*NREQ-1:0] req_data0  = '0;
    logic [NREQ-1:0]   req_ready0;
    logic              tx_enable0;
    logic [7:0]        tx_din0;
    logic              tx_parity0;
    logic              tx_sending0 = 1'b0;
    logic              busy0;
    logic [ID_W-1:0]   grant_id0;
    logic              start_err0;

    uart_tx_sched #(.NREQ(NREQ), .ID_W(ID_W), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) u_dut (
        .baud_clk(baud_clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .parity_odd(parity_odd), .err_clr(err_clr),
        .tx_enable(tx_enable), .tx_din(tx_din), .tx_parity(tx_parity),
        .tx_sending(tx_sending), .busy(busy), .grant_id(grant_id), .start_err(start_err)
    );

    uart_tx_sched #(.NREQ(NREQ), .ID_W(ID_W), .GAP_CYCLES(0), .START_TIMEOUT(TMO)) u_gap0 (
        .baud_clk(baud_clk), .reset(reset), .req_valid(req_valid0), .req_data(req_data0),
        .req_ready(req_ready0), .parity_odd(parity_odd), .err_clr(err_clr),
        .tx_enable(tx_enable0), .tx_din(tx_din0), .tx_parity(tx_parity0),
        .tx_sending(tx_sending0), .busy(busy0), .grant_id(grant_id0), .start_err(start_err0)
    );

    always #5 baud_clk = ~baud_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int              id;
        logic [7:0]      din;
        logic            par;
        logic [ID_W-1:0] gid;
    } grant_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Bench state: serializer model, logs and reference pointer.
    int              cyc = 0;
    bit              model_en = 1'b1;
    bit              auto_rearm = 1'b0;
    bit              ser_sending = 1'b0;
    bit              ser_pending = 1'b0;
    int              ser_cnt = 0;
    logic [10:0]     ser_frame = '0;
    int              pulse_viol = 0;
    logic [NREQ-1:0] prev_ready = '0;
    logic            prev_en = 1'b0;
    logic            prev_busy = 1'b0;
    logic            prev_send = 1'b0;
    int              busy_fall_cyc = 0;
    int              send_fall_cyc = 0;
    int              exp_last = NREQ - 1;
    grant_t          grant_q[$];
    int              en_cyc_q[$];
    bit              line_q[$];

    // Reference arbitration: first pending requester after last_id, with wrap.
    function automatic int rr_pick(input logic [NREQ-1:0] pending, input int last_id);
        for (int k = 1; k <= NREQ; k++)
            if (pending[(last_id + k) % NREQ]) return (last_id + k) % NREQ;
        return -1;
    endfunction

    // One clock: advance the serializer model, log grants/enables, retire acked requests.
    task automatic step();
        grant_t g;
        @(posedge baud_clk);
        #1;
        cyc++;
        if (ser_sending) begin
            ser_cnt++;
            if (ser_cnt % BIT_CYC == BIT_CYC / 2) line_q.push_back(ser_frame[ser_cnt / BIT_CYC]);
            if (ser_cnt == FRAME_CYC) ser_sending = 1'b0;
        end
        if (ser_pending) begin
            ser_pending = 1'b0;
            ser_sending = 1'b1;
            ser_cnt     = 0;
        end
        if (tx_enable) begin
            en_cyc_q.push_back(cyc);
            if (prev_en) pulse_viol++;
            if (model_en) begin
                ser_pending = 1'b1;
                ser_frame   = {1'b1, tx_parity, tx_din, 1'b0};
            end
        end
        if (req_ready != '0) begin
            if (prev_ready != '0 || !$onehot(req_ready)) pulse_viol++;
            g.id = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g.id = i;
            g.din = tx_din;
            g.par = tx_parity;
            g.gid = grant_id;
            grant_q.push_back(g);
            if (!auto_rearm) req_valid = req_valid & ~req_ready;
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        tx_sending = model_en & ser_sending;
        if (prev_send && !tx_sending) send_fall_cyc = cyc;
        prev_ready = req_ready;
        prev_en    = tx_enable;
        prev_busy  = busy;
        prev_send  = tx_sending;
    endtask

    task automatic clear_logs();
        grant_q.delete();
        en_cyc_q.delete();
        line_q.delete();
        pulse_viol = 0;
    endtask

    task automatic wait_grants(input string name, input int n, input int budget);
        int t = 0;
        while (grant_q.size() < n && t < budget) begin
            step();
            t++;
        end
        n_tests++;
        if (grant_q.size() < n) begin
            n_fail++;
            $display("FAIL %s_grant_timeout: got %0d grants, expected %0d", name, grant_q.size(), n);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int t = 0;
        while ((busy || ser_sending || ser_pending) && t < budget) begin
            step();
            t++;
        end
        n_tests++;
        if (busy) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy still %0b, expected 0", name, busy);
        end
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        req_valid   = '0;
        req_valid0  = '0;
        err_clr     = 1'b0;
        tx_sending0 = 1'b0;
        ser_sending = 1'b0;
        ser_pending = 1'b0;
        tx_sending  = 1'b0;
        exp_last    = NREQ - 1;
        repeat (3) @(negedge baud_clk);
        reset = 1'b1;
        @(negedge baud_clk);
    endtask

    task automatic test_reset();
        logic [NREQ+ID_W+12:0] outs;
        req_valid = '1;
        #2;
        reset = 1'b0;
        repeat (2) @(negedge baud_clk);
        outs = {req_ready, tx_enable, tx_din, tx_parity, busy, grant_id, start_err};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h, expected 0", outs);
        end
        outs = {req_ready0, tx_enable0, tx_din0, tx_parity0, busy0, grant_id0, start_err0};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_gap0: got %0h, expected 0", outs);
        end
        req_valid = '0;
        reset = 1'b1;
        exp_last = NREQ - 1;
        step();
        n_tests++;
        if (busy !== 1'b0 || start_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%0b err=%0b, expected 0/0", busy, start_err);
        end
    endtask

    task automatic test_single();
        logic [10:0] exp_line = 11'b1_0_10100101_0;
        logic [10:0] got_line = '0;
        clear_logs();
        parity_odd = 1'b0;
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        wait_grants("single", 1, 20);
        wait_idle("single", 400);
        exp_last = 2;
        n_tests++;
        if (grant_q.size() != 1 || grant_q[0].id != 2 || grant_q[0].din !== 8'hA5 ||
            grant_q[0].par !== 1'b0 || grant_q[0].gid !== 2'd2) begin
            n_fail++;
            $display("FAIL single_capture: got n=%0d id=%0d din=%0h par=%0b gid=%0d, expected 1/2/a5/0/2",
                     grant_q.size(), (grant_q.size() > 0) ? grant_q[0].id : -1,
                     tx_din, tx_parity, grant_id);
        end
        n_tests++;
        if (en_cyc_q.size() != 1 || pulse_viol != 0) begin
            n_fail++;
            $display("FAIL single_pulses: got enables=%0d viol=%0d, expected 1/0", en_cyc_q.size(), pulse_viol);
        end
        for (int k = 0; k < 11 && k < line_q.size(); k++) got_line[k] = line_q[k];
        n_tests++;
        if (line_q.size() != 11 || got_line !== exp_line) begin
            n_fail++;
            $display("FAIL single_serial_line: got %b (%0d bits), expected %b", got_line, line_q.size(), exp_line);
        end
        n_tests++;
        if (busy_fall_cyc - send_fall_cyc != GAP + 1) begin
            n_fail++;
            $display("FAIL single_gap: got busy fall %0d cycles after sending, expected %0d",
                     busy_fall_cyc - send_fall_cyc, GAP + 1);
        end
    endtask

    task automatic test_round_robin();
        int exp_id;
        apply_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
        auto_rearm = 1'b1;
        req_valid  = '1;
        wait_grants("rr", 5, 5 * (SPACING + 10));
        req_valid  = '0;
        auto_rearm = 1'b0;
        wait_idle("rr", 400);
        for (int k = 0; k < 5 && k < grant_q.size(); k++) begin
            exp_id = rr_pick('1, exp_last);
            exp_last = exp_id;
            n_tests++;
            if (grant_q[k].id != exp_id || grant_q[k].din !== 8'(8'h10 + exp_id)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got id=%0d din=%0h, expected id=%0d din=%0h",
                         k, grant_q[k].id, grant_q[k].din, exp_id, 8'h10 + exp_id);
            end
        end
        for (int k = 0; k + 1 < en_cyc_q.size(); k++) begin
            n_tests++;
            if (en_cyc_q[k+1] - en_cyc_q[k] != SPACING) begin
                n_fail++;
                $display("FAIL rr_spacing[%0d]: got %0d cycles, expected %0d",
                         k, en_cyc_q[k+1] - en_cyc_q[k], SPACING);
            end
        end
        n_tests++;
        if (pulse_viol != 0 || en_cyc_q.size() != 5) begin
            n_fail++;
            $display("FAIL rr_pulses: got viol=%0d enables=%0d, expected 0/5", pulse_viol, en_cyc_q.size());
        end
    endtask

    task automatic test_parity();
        logic [7:0] data_t[4] = '{8'h00, 8'h00, 8'h07, 8'h07};
        logic       mode_t[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       exp_t[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        int r;
        for (int c = 0; c < 4; c++) begin
            clear_logs();
            r = $urandom_range(0, NREQ - 1);
            req_data[8*r +: 8] = data_t[c];
            parity_odd = mode_t[c];
            req_valid[r] = 1'b1;
            wait_grants("parity", 1, 20);
            parity_odd = ~parity_odd;
            wait_idle("parity", 400);
            exp_last = r;
            n_tests++;
            if (tx_parity !== exp_t[c] || tx_din !== data_t[c]) begin
                n_fail++;
                $display("FAIL parity[%0d]: got din=%0h par=%0b, expected din=%0h par=%0b",
                         c, tx_din, tx_parity, data_t[c], exp_t[c]);
            end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask, pending;
        logic [7:0]      bytes[NREQ];
        logic            mode;
        int              exp_id;
        logic            exp_par;
        for (int round = 0; round < 10; round++) begin
            clear_logs();
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < NREQ; i++) begin
                bytes[i] = 8'($urandom);
                req_data[8*i +: 8] = bytes[i];
            end
            parity_odd = mode;
            req_valid  = mask;
            wait_grants("random", $countones(mask), $countones(mask) * (SPACING + 10));
            wait_idle("random", 400);
            pending = mask;
            for (int k = 0; k < grant_q.size(); k++) begin
                exp_id  = rr_pick(pending, exp_last);
                if (exp_id < 0) exp_id = 0;
                exp_par = 1'($countones(bytes[exp_id]) % 2) ^ mode;
                pending[exp_id] = 1'b0;
                exp_last = exp_id;
                n_tests++;
                if (grant_q[k].id != exp_id || grant_q[k].din !== bytes[exp_id] ||
                    grant_q[k].par !== exp_par || grant_q[k].gid !== ID_W'(exp_id)) begin
                    n_fail++;
                    $display("FAIL random[%0d.%0d]: got id=%0d din=%0h par=%0b gid=%0d, expected id=%0d din=%0h par=%0b",
                             round, k, grant_q[k].id, grant_q[k].din, grant_q[k].par, grant_q[k].gid,
                             exp_id, bytes[exp_id], exp_par);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int t;
        int c0;
        model_en = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            clear_logs();
            req_data[7:0] = 8'h3C;
            req_valid[0]  = 1'b1;
            wait_grants("timeout", 1, 20);
            exp_last = 0;
            c0 = (en_cyc_q.size() > 0) ? en_cyc_q[0] : cyc;
            if (pass == 1) err_clr = 1'b1;
            t = 0;
            while (!start_err && t < 20) begin
                step();
                t++;
            end
            n_tests++;
            if (start_err !== 1'b1 || cyc - c0 != TMO + 1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_set[%0d]: got err=%0b after %0d cycles busy=%0b, expected 1 after %0d busy=0",
                         pass, start_err, cyc - c0, busy, TMO + 1);
            end
            err_clr = 1'b0;
            step();
            n_tests++;
            if (start_err !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_sticky[%0d]: got err=%0b, expected 1", pass, start_err);
            end
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            n_tests++;
            if (start_err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_clear[%0d]: got err=%0b, expected 0", pass, start_err);
            end
        end
        model_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [NREQ+ID_W+12:0] outs;
        clear_logs();
        req_data[23:16] = 8'hC3;
        req_valid[2] = 1'b1;
        wait_grants("reset_mid", 1, 20);
        repeat (30) step();
        n_tests++;
        if (busy !== 1'b1 || tx_din !== 8'hC3 || grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got busy=%0b din=%0h gid=%0d, expected 1/c3/2", busy, tx_din, grant_id);
        end
        reset = 1'b0;
        #1;
        outs = {req_ready, tx_enable, tx_din, tx_parity, busy, grant_id, start_err};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %0h, expected 0", outs);
        end
        ser_sending = 1'b0;
        ser_pending = 1'b0;
        tx_sending  = 1'b0;
        exp_last    = NREQ - 1;
        clear_logs();
        req_data[15:8]  = 8'h5A;
        req_data[31:24] = 8'h81;
        req_valid = 4'b1010;
        repeat (2) @(negedge baud_clk);
        reset = 1'b1;
        wait_grants("reset_mid", 2, 2 * (SPACING + 10));
        wait_idle("reset_mid", 400);
        n_tests++;
        if (grant_q.size() != 2 || grant_q[0].id != 1 || grant_q[1].id != 3 || grant_q[0].din !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_mid_regrant: got n=%0d first=%0d, expected 2 grants 1 then 3",
                     grant_q.size(), (grant_q.size() > 0) ? grant_q[0].id : -1);
        end
        exp_last = 3;
    endtask

    task automatic test_gap0();
        int  n;
        bit  seen;
        req_data0  = 32'($urandom);
        req_valid0 = 4'b0011;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(posedge baud_clk); #1;
            n++;
            if (tx_enable0) seen = 1'b1;
        end
        n_tests++;
        if (!seen || grant_id0 !== 2'd0 || tx_din0 !== req_data0[7:0]) begin
            n_fail++;
            $display("FAIL gap0_first: got seen=%0b gid=%0d din=%0h, expected 1/0/%0h", seen, grant_id0, tx_din0, req_data0[7:0]);
        end
        req_valid0 = req_valid0 & ~req_ready0;
        @(posedge baud_clk); #1;
        tx_sending0 = 1'b1;
        repeat (5) begin @(posedge baud_clk); #1; end
        n_tests++;
        if (busy0 !== 1'b1 || tx_enable0 !== 1'b0) begin
            n_fail++;
            $display("FAIL gap0_busy: got busy=%0b en=%0b, expected 1/0", busy0, tx_enable0);
        end
        tx_sending0 = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(posedge baud_clk); #1;
            n++;
            if (tx_enable0) seen = 1'b1;
        end
        n_tests++;
        if (!seen || n != 2 || grant_id0 !== 2'd1) begin
            n_fail++;
            $display("FAIL gap0_spacing: got enable %0d cycles after sending fell (seen=%0b gid=%0d), expected 2 gid=1",
                     n, seen, grant_id0);
        end
        req_valid0 = req_valid0 & ~req_ready0;
        @(posedge baud_clk); #1;
        tx_sending0 = 1'b1;
        repeat (5) begin @(posedge baud_clk); #1; end
        tx_sending0 = 1'b0;
        @(posedge baud_clk); #1;
        n_tests++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL gap0_idle: got busy=%0b one cycle after sending fell, expected 0", busy0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_parity();
        test_random();
        test_timeout();
        test_reset_mid();
        test_gap0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
